wshb_arbiter_rr: RTL and testbench
==================================

Name: wshb_arbiter_rr

Overview:
- N-master to 1-slave Wishbone B4 arbiter; replaces the fixed two-master token interconnect in front of the SDRAM controller.
- Round-robin grant among NB_MASTERS requesters, with optional bounded ownership (preemption after MAX_ACKS acknowledges, at a transaction boundary only).
- Masters are flattened into packed vectors: master i occupies slice i.
- Responses are routed only to the current owner.

Parameters:
- NB_MASTERS, 2, number of masters (>=2); IW = $clog2(NB_MASTERS).
- AW, 32, address width.
- DW, 16, data width (multiple of 8); SW = DW/8.
- MAX_ACKS, 0, acks granted per tenure before forced rotation; 0 = unlimited.

Ports:
- clk  in  1  Wishbone clock (SDRAM domain).
- rst_n  in  1  asynchronous active-low reset.
- m_cyc  in  NB_MASTERS  cycle request per master.
- m_stb  in  NB_MASTERS  strobe per master.
- m_we  in  NB_MASTERS  write enable per master.
- m_adr  in  NB_MASTERS*AW  addresses.
- m_dat_ms  in  NB_MASTERS*DW  write data.
- m_sel  in  NB_MASTERS*SW  byte selects.
- m_cti  in  NB_MASTERS*3  cycle type.
- m_bte  in  NB_MASTERS*2  burst type.
- m_ack  out  NB_MASTERS  ack, owner bit only.
- m_rty  out  NB_MASTERS  retry, owner bit only.
- m_err  out  NB_MASTERS  error, owner bit only.
- m_dat_sm  out  DW  read data; broadcast, qualified by m_ack.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  AW;  s_dat_ms  out  DW;  s_sel  out  SW;  s_cti  out  3;  s_bte  out  2.
- s_ack, s_rty, s_err  in  1 each  from slave.
- s_dat_sm  in  DW  read data from slave.
- grant  out  NB_MASTERS  one-hot current owner, all zero when idle (debug/status).

Behaviour:
- State: IDLE / OWNED. Registers: owner (IW bits), last (IW bits), ack_cnt.
- Reset (async, rst_n=0): IDLE; grant=0; last=NB_MASTERS-1, so master 0 has first priority; ack_cnt=0.
- Outputs during reset: s_cyc=s_stb=s_we=0, s_adr/s_dat_ms/s_sel/s_cti/s_bte=0, m_ack=m_rty=m_err=0.
- Output datapath, combinational from the registered owner:
  - OWNED: s_* = owner's m_*; m_ack/m_rty/m_err[owner] = s_ack/s_rty/s_err; all other bits 0.
  - IDLE: all s_* forced to 0.
- m_dat_sm = s_dat_sm always.
- Round-robin pick: the first i with m_cyc[i]=1, scanning last+1, last+2, ... modulo NB_MASTERS.
- IDLE: if any m_cyc is set, at the next edge owner=pick, last=pick, ack_cnt=0, go OWNED. Latency from request to s_cyc is 1 cycle.
- OWNED, m_cyc[owner]=0: at the next edge grant passes directly to the next pick, with no idle gap. If there is no other requester, go IDLE.
- OWNED, preemption (MAX_ACKS>0):
  - ack_cnt increments on each s_ack.
  - When s_ack arrives with ack_cnt==MAX_ACKS-1, s_cti==000 or 111 (end of transaction), and another master has m_cyc=1: rotate to the next pick at that edge.
  - The preempted master keeps its m_cyc high and simply sees no ack until regranted.
  - If no other master is requesting, ack_cnt saturates at MAX_ACKS-1 and ownership continues.
- Never rotate mid-burst. An ack with cti=010 (incrementing burst) never triggers rotation, even when ack_cnt saturates.
- rty/err count as transaction completion for the preemption rule, as ack does; they do not increment ack_cnt.
- Simultaneous events: release by the owner and a new request in the same cycle resolve via pick. The releasing owner is excluded only when its m_cyc=0.
- If m_cyc[owner] drops while the slave asserts s_ack in the same cycle, the ack is forwarded to the owner that cycle.
- rst_n asserted mid-transfer: immediate return to the reset values above, including deassertion of s_cyc (asynchronous).

Test Plan:
- NB_MASTERS=3, all idle, reset released → s_cyc=0, grant=000. Master 1 asserts cyc+stb → grant=010 and s_cyc=1 one cycle later; m_ack[1] follows s_ack, m_ack[0] and m_ack[2] stay 0.
- All three assert cyc continuously, each drops cyc after 2 acks → grant sequence 001, 010, 100, 001 with zero idle cycles between tenures.
- MAX_ACKS=4; master 0 issues an 8-beat incrementing burst (cti=010 ... 111) while master 2 requests → no rotation until the ack with cti=111; grant moves to 100 on that edge.
- MAX_ACKS=4; master 0 issues classic single reads and master 1 requests → after the 4th ack, grant=010; master 0 sees m_ack[0]=0 while waiting and regains the grant when master 1 releases.
- Slave returns s_err on a master 2 access → m_err[2]=1 for exactly that cycle; m_err[0]=m_err[1]=0.
- rst_n pulsed low mid-burst with grant=010 → s_cyc and grant go to 0 asynchronously. After release with master 0 and master 1 both requesting, master 0 is granted first.

Source files
------------

// File: rtl/wshb_arbiter_rr.sv
// Round-robin N-master to 1-slave Wishbone B4 arbiter with optional bounded
// ownership: a tenure may be cut after MAX_ACKS acks, only at a transaction end.
module wshb_arbiter_rr #(
  parameter int NB_MASTERS = 2,
  parameter int AW         = 32,
  parameter int DW         = 16,
  parameter int MAX_ACKS   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NB_MASTERS-1:0]      m_cyc,
  input  logic [NB_MASTERS-1:0]      m_stb,
  input  logic [NB_MASTERS-1:0]      m_we,
  input  logic [NB_MASTERS*AW-1:0]   m_adr,
  input  logic [NB_MASTERS*DW-1:0]   m_dat_ms,
  input  logic [NB_MASTERS*DW/8-1:0] m_sel,
  input  logic [NB_MASTERS*3-1:0]    m_cti,
  input  logic [NB_MASTERS*2-1:0]    m_bte,
  output logic [NB_MASTERS-1:0]      m_ack,
  output logic [NB_MASTERS-1:0]      m_rty,
  output logic [NB_MASTERS-1:0]      m_err,
  output logic [DW-1:0]              m_dat_sm,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [AW-1:0]              s_adr,
  output logic [DW-1:0]              s_dat_ms,
  output logic [DW/8-1:0]            s_sel,
  output logic [2:0]                 s_cti,
  output logic [1:0]                 s_bte,
  input  logic                       s_ack,
  input  logic                       s_rty,
  input  logic                       s_err,
  input  logic [DW-1:0]              s_dat_sm,
  output logic [NB_MASTERS-1:0]      grant
);

  localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int SW = DW / 8;
  localparam int CW = (MAX_ACKS > 1) ? $clog2(MAX_ACKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MAX_ACKS > 0) ? CW'(MAX_ACKS - 1) : '0;
  localparam logic [IW-1:0] LAST_INIT = IW'(NB_MASTERS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_ackCnt;
  logic [IW-1:0]   w_nextOwner;
  logic [IW-1:0]   w_nextLast;
  logic [CW-1:0]   w_nextCnt;

  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic            w_anyReq;
  logic            w_ownerCyc;
  logic            w_otherReq;
  logic            w_done;
  logic            w_eot;
  logic            w_rotate;

  // Requesters above r_last win first, then the wrap-around part up to r_last.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (!w_found && m_cyc[i] && (IW'(i) > r_last)) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (!w_found && m_cyc[i] && (IW'(i) <= r_last)) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
  end

  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_ms   = '0;
    s_sel      = '0;
    s_cti      = '0;
    s_bte      = '0;
    m_ack      = '0;
    m_rty      = '0;
    m_err      = '0;
    grant      = '0;
    w_ownerCyc = 1'b0;
    w_otherReq = 1'b0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if ((r_state == OWNED) && (IW'(i) == r_owner)) begin
        s_cyc      = m_cyc[i];
        s_stb      = m_stb[i];
        s_we       = m_we[i];
        s_adr      = m_adr[i*AW +: AW];
        s_dat_ms   = m_dat_ms[i*DW +: DW];
        s_sel      = m_sel[i*SW +: SW];
        s_cti      = m_cti[i*3 +: 3];
        s_bte      = m_bte[i*2 +: 2];
        m_ack[i]   = s_ack;
        m_rty[i]   = s_rty;
        m_err[i]   = s_err;
        grant[i]   = 1'b1;
        w_ownerCyc = m_cyc[i];
      end else if (m_cyc[i]) begin
        w_otherReq = 1'b1;
      end
    end
  end

  assign m_dat_sm = s_dat_sm;
  assign w_anyReq = |m_cyc;
  assign w_done   = s_ack | s_rty | s_err;
  assign w_eot    = (s_cti == 3'b000) || (s_cti == 3'b111);
  // Incrementing-burst beats never end a transaction, so a saturated count waits.
  assign w_rotate = (MAX_ACKS > 0) && w_done && w_eot &&
                    (r_ackCnt == CNT_LAST) && w_otherReq;

  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    w_nextLast  = r_last;
    w_nextCnt   = r_ackCnt;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = OWNED;
          w_nextOwner = w_pick;
          w_nextLast  = w_pick;
          w_nextCnt   = '0;
        end
      end
      OWNED: begin
        if (!w_ownerCyc) begin
          if (w_anyReq) begin
            w_nextOwner = w_pick;
            w_nextLast  = w_pick;
            w_nextCnt   = '0;
          end else begin
            w_nextState = IDLE;
          end
        end else if (w_rotate) begin
          w_nextOwner = w_pick;
          w_nextLast  = w_pick;
          w_nextCnt   = '0;
        end else if ((MAX_ACKS > 0) && s_ack && (r_ackCnt != CNT_LAST)) begin
          w_nextCnt = r_ackCnt + CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_last   <= LAST_INIT;
      r_ackCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_owner  <= w_nextOwner;
      r_last   <= w_nextLast;
      r_ackCnt <= w_nextCnt;
    end
  end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Scoreboard bench for wshb_arbiter_rr: three masters, tenure bounded at four acks.
module tb_wshb_arbiter_rr;

  localparam int NB = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NB-1:0]    m_cyc, m_stb, m_we;
  logic [NB*AW-1:0] m_adr;
  logic [NB*DW-1:0] m_dat_ms;
  logic [NB*SW-1:0] m_sel;
  logic [NB*3-1:0]  m_cti;
  logic [NB*2-1:0]  m_bte;
  logic [NB-1:0]    m_ack, m_rty, m_err;
  logic [DW-1:0]    m_dat_sm;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_ms;
  logic [SW-1:0]    s_sel;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic             s_ack, s_rty, s_err;
  logic [DW-1:0]    s_dat_sm;
  logic [NB-1:0]    grant;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [2:0]  grant;
    logic        sCyc;
    logic [2:0]  ack;
    logic [2:0]  rty;
    logic [2:0]  err;
    logic [15:0] adr;
    logic [2:0]  cti;
    logic [15:0] dat;
  } expT;

  expT sbQ[$];
  expT monE;

  wshb_arbiter_rr #(.NB_MASTERS(NB), .AW(AW), .DW(DW), .MAX_ACKS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_rty(m_rty), .m_err(m_err), .m_dat_sm(m_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_rty(s_rty), .s_err(s_err), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One bus cycle: drive after the rising edge, queue what the DUT must show mid-cycle.
  task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] cti0,
                               input logic ack, input logic rty, input logic err,
                               input logic [2:0] eGrant, input logic eSCyc,
                               input logic [2:0] eAck, input logic [2:0] eRty,
                               input logic [2:0] eErr);
    expT e;
    @(posedge clk);
    #1;
    m_cyc    = cyc;
    m_stb    = cyc;
    m_cti    = {6'b000000, cti0};
    s_ack    = ack;
    s_rty    = rty;
    s_err    = err;
    s_dat_sm = 16'($urandom);
    e.grant  = eGrant;
    e.sCyc   = eSCyc;
    e.ack    = eAck;
    e.rty    = eRty;
    e.err    = eErr;
    e.adr    = (eGrant == 3'b001) ? 16'hA000 :
               (eGrant == 3'b010) ? 16'hA001 :
               (eGrant == 3'b100) ? 16'hA002 : 16'h0000;
    e.cti    = (eGrant == 3'b001) ? cti0 : 3'b000;
    e.dat    = s_dat_sm;
    sbQ.push_back(e);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    m_cyc = '0;
    m_stb = '0;
    m_cti = '0;
    s_ack = 1'b0;
    s_rty = 1'b0;
    s_err = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstGrant", 32'(grant), 32'h0);
    checkOutput("rstSCyc", 32'(s_cyc), 32'h0);
    checkOutput("rstSAdr", 32'(s_adr), 32'h0);
    checkOutput("rstMAck", 32'(m_ack), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      monE = sbQ.pop_front();
      checkOutput("grant", 32'(grant), 32'(monE.grant));
      checkOutput("sCyc", 32'(s_cyc), 32'(monE.sCyc));
      checkOutput("mAck", 32'(m_ack), 32'(monE.ack));
      checkOutput("mRty", 32'(m_rty), 32'(monE.rty));
      checkOutput("mErr", 32'(m_err), 32'(monE.err));
      checkOutput("sAdr", 32'(s_adr), 32'(monE.adr));
      checkOutput("sCti", 32'(s_cti), 32'(monE.cti));
      checkOutput("mDatSm", 32'(m_dat_sm), 32'(monE.dat));
    end
  end

  initial begin
    rst_n    = 1'b0;
    m_cyc    = '0;
    m_stb    = '0;
    m_we     = 3'b101;
    m_adr    = {16'hA002, 16'hA001, 16'hA000};
    m_dat_ms = {16'h1002, 16'h1001, 16'h1000};
    m_sel    = '1;
    m_cti    = '0;
    m_bte    = '0;
    s_ack    = 1'b0;
    s_rty    = 1'b0;
    s_err    = 1'b0;
    s_dat_sm = '0;

    // Single requester: one-cycle grant latency, ack routed to owner only.
    resetDut();
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b010, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b010, 3'b000, 0, 0, 0, 3'b010, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b010, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b010, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);

    // All three request; each releases after two acks; no idle gap between tenures.
    resetDut();
    applyStimulus(3'b111, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b111, 3'b000, 1, 0, 0, 3'b001, 1, 3'b001, 3'b000, 3'b000);
    applyStimulus(3'b111, 3'b000, 1, 0, 0, 3'b001, 1, 3'b001, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 0, 0, 0, 3'b001, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b101, 3'b000, 0, 0, 0, 3'b010, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b101, 3'b000, 1, 0, 0, 3'b100, 1, 3'b100, 3'b000, 3'b000);
    applyStimulus(3'b101, 3'b000, 1, 0, 0, 3'b100, 1, 3'b100, 3'b000, 3'b000);
    applyStimulus(3'b011, 3'b000, 0, 0, 0, 3'b100, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b011, 3'b000, 0, 0, 0, 3'b001, 1, 3'b000, 3'b000, 3'b000);

    // Eight-beat incrementing burst: rotation waits for the cti=111 beat.
    resetDut();
    applyStimulus(3'b101, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    for (int beat = 1; beat <= 8; beat++) begin
      applyStimulus(3'b101, (beat == 8) ? 3'b111 : 3'b010, 1, 0, 0,
                    3'b001, 1, 3'b001, 3'b000, 3'b000);
    end
    applyStimulus(3'b101, 3'b000, 0, 0, 0, 3'b100, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b101, 3'b000, 1, 0, 0, 3'b100, 1, 3'b100, 3'b000, 3'b000);

    // Classic singles: preempted after the fourth ack, regranted on release.
    resetDut();
    applyStimulus(3'b011, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(3'b011, 3'b000, 1, 0, 0, 3'b001, 1, 3'b001, 3'b000, 3'b000);
    end
    applyStimulus(3'b011, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b011, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b001, 3'b000, 1, 0, 0, 3'b010, 0, 3'b010, 3'b000, 3'b000);
    applyStimulus(3'b001, 3'b000, 0, 0, 0, 3'b001, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b001, 0, 3'b000, 3'b000, 3'b000);

    // Error and retry responses reach master 2 only, for exactly one cycle.
    resetDut();
    applyStimulus(3'b100, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b100, 3'b000, 0, 0, 0, 3'b100, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b100, 3'b000, 0, 0, 1, 3'b100, 1, 3'b000, 3'b000, 3'b100);
    applyStimulus(3'b100, 3'b000, 0, 1, 0, 3'b100, 1, 3'b000, 3'b100, 3'b000);
    applyStimulus(3'b100, 3'b000, 0, 0, 0, 3'b100, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b100, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);

    // Asynchronous reset mid-transfer, then master 0 wins a tie.
    resetDut();
    applyStimulus(3'b010, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b010, 3'b000, 0, 0, 0, 3'b010, 1, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b010, 3'b000, 1, 0, 0, 3'b010, 1, 3'b010, 3'b000, 3'b000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncGrant", 32'(grant), 32'h0);
    checkOutput("asyncSCyc", 32'(s_cyc), 32'h0);
    checkOutput("asyncMAck", 32'(m_ack), 32'h0);
    resetDut();
    applyStimulus(3'b011, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);
    applyStimulus(3'b011, 3'b000, 0, 0, 0, 3'b001, 1, 3'b000, 3'b000, 3'b000);

    @(negedge clk);
    #2;
    checkOutput("sbDrained", 32'(sbQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
